// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-write store buffer between CPU store port and req/ack data memory
// In-order FIFO drain with youngest-match load forwarding; CPU stalls only on a store into a full buffer.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_memwrite,
  input  logic [AW-1:0]              cpu_addr,
  input  logic [DW-1:0]              cpu_wdata,
  output logic                       cpu_stall,
  input  logic [AW-1:0]              cpu_raddr,
  output logic                       fwd_hit,
  output logic [DW-1:0]              fwd_data,
  output logic                       mem_req,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic                       mem_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [AW-1:0]   buf_addr_q [DEPTH];
  logic [AW-1:0]   buf_addr_d [DEPTH];
  logic [DW-1:0]   buf_data_q [DEPTH];
  logic [DW-1:0]   buf_data_d [DEPTH];

  logic            full;
  logic            push;
  logic            pop;
  logic [PW-1:0]   rd_next;
  logic [PW-1:0]   fwd_idx;
  logic            unused_raddr_bits;

  assign full      = (count_q == CW'(DEPTH));
  assign push      = cpu_memwrite & ~full;
  assign pop       = (state_q == BUSY) & mem_ack;
  assign rd_next   = rd_ptr_q + PW'(1);
  assign cpu_stall = cpu_memwrite & full;
  assign mem_req   = (state_q == BUSY);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);

  assign unused_raddr_bits = ^cpu_raddr[1:0];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;

    if (push) begin
      buf_addr_d[wr_ptr_q] = cpu_addr;
      buf_data_d[wr_ptr_q] = cpu_wdata;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_next;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          mem_addr_d  = buf_addr_q[rd_ptr_q];
          mem_wdata_d = buf_data_q[rd_ptr_q];
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          // A store pushed into a buffer whose last entry is leaving becomes the next head directly.
          if (count_q > CW'(1)) begin
            mem_addr_d  = buf_addr_q[rd_next];
            mem_wdata_d = buf_data_q[rd_next];
          end else if (push) begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Walk oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (buf_addr_q[fwd_idx][AW-1:2] == cpu_raddr[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data_q[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - scoreboard bench for dmem_store_buffer
// Stimulus queues expected memory writes; a negedge monitor pops them on each req/ack handshake.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_memwrite;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_raddr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  count;
  logic        empty;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_memwrite(cpu_memwrite), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_raddr(cpu_raddr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .empty(empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
    cpu_memwrite = 1'b1;
    cpu_addr     = a;
    cpu_wdata    = d;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive_store(a, d);
    exp_q.push_back({a, d});
    cyc();
    cpu_memwrite = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    mem_ack = 1'b1;
    while (!empty && n < 20) begin
      cyc();
      n++;
    end
    mem_ack = 1'b0;
    chk({name, "_drain_done"}, {63'd0, empty}, 64'd1);
  endtask

  // Handshake is taken at the next rising edge; inputs are stable by the falling edge.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset && mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {mem_addr, mem_wdata}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("mem_write", {mem_addr, mem_wdata}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cpu_memwrite = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_raddr = '0; mem_ack = 1'b0;

    // 1: reset then idle
    cyc(); cyc();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t1_req",   {63'd0, mem_req},   64'd0);
      chk("t1_empty", {63'd0, empty},     64'd1);
      chk("t1_count", {61'd0, count},     64'd0);
      chk("t1_stall", {63'd0, cpu_stall}, 64'd0);
      chk("t1_fwd",   {63'd0, fwd_hit},   64'd0);
    end
    chk("t1_addr", {32'd0, mem_addr}, 64'd0);

    // 2: single store, ack on the third request cycle
    store(32'h54, 32'h7);
    chk("t2_count1", {61'd0, count}, 64'd1);
    chk("t2_req_lat", {63'd0, mem_req}, 64'd0);
    cpu_raddr = 32'h57; #1;
    chk("t2_fwd_hit",  {63'd0, fwd_hit}, 64'd1);
    chk("t2_fwd_data", {32'd0, fwd_data}, 64'h7);
    cyc();
    chk("t2_req", {63'd0, mem_req}, 64'd1);
    chk("t2_addr", {mem_addr, mem_wdata}, {32'h54, 32'h7});
    cyc(); cyc();
    chk("t2_hold", {mem_addr, mem_wdata, 1'b0} >> 1, {32'h54, 32'h7});
    chk("t2_req_hold", {63'd0, mem_req}, 64'd1);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("t2_req_drop", {63'd0, mem_req}, 64'd0);
    chk("t2_empty", {63'd0, empty}, 64'd1);

    // 3: fill and stall
    for (int i = 0; i < 4; i++) store(32'h10 + 32'(4*i), 32'(i+1));
    chk("t3_count4", {61'd0, count}, 64'd4);
    drive_store(32'h20, 32'h5); #1;
    chk("t3_stall", {63'd0, cpu_stall}, 64'd1);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("t3_count3", {61'd0, count}, 64'd3);
    chk("t3_unstall", {63'd0, cpu_stall}, 64'd0);
    exp_q.push_back({32'h20, 32'h5});
    cyc();
    cpu_memwrite = 1'b0;
    chk("t3_count4b", {61'd0, count}, 64'd4);
    drain("t3");

    // 4: forwarding priority and same-cycle push invisibility
    store(32'h40, 32'hAA);
    store(32'h40, 32'hBB);
    cpu_raddr = 32'h42; #1;
    chk("t4_hit",  {63'd0, fwd_hit}, 64'd1);
    chk("t4_data", {32'd0, fwd_data}, 64'hBB);
    cpu_raddr = 32'h44; #1;
    chk("t4_miss_hit",  {63'd0, fwd_hit}, 64'd0);
    chk("t4_miss_data", {32'd0, fwd_data}, 64'd0);
    drive_store(32'h44, 32'hCC); #1;
    chk("t4_push_nofwd", {63'd0, fwd_hit}, 64'd0);
    exp_q.push_back({32'h44, 32'hCC});
    cyc();
    cpu_memwrite = 1'b0;
    chk("t4_push_fwd", {32'd0, fwd_data}, 64'hCC);

    // 5: back-to-back drain of the three entries above
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t5_req_b2b", {63'd0, mem_req}, 64'd1);
      cyc();
    end
    mem_ack = 1'b0;
    chk("t5_req_drop", {63'd0, mem_req}, 64'd0);
    chk("t5_empty", {63'd0, empty}, 64'd1);

    // 5b: push during pop keeps count
    store(32'h60, 32'h11);
    store(32'h64, 32'h12);
    store(32'h68, 32'h13);
    mem_ack = 1'b1;
    store(32'h6C, 32'h14);
    chk("t5_count_same", {61'd0, count}, 64'd3);
    drain("t5b");

    // 6: reset mid-drain discards everything
    store(32'h80, 32'h21);
    store(32'h84, 32'h22);
    store(32'h88, 32'h23);
    chk("t6_busy", {63'd0, mem_req}, 64'd1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    exp_q.delete();
    chk("t6_req",   {63'd0, mem_req}, 64'd0);
    chk("t6_count", {61'd0, count},   64'd0);
    chk("t6_addr",  {32'd0, mem_addr}, 64'd0);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    cyc();
    chk("t6_count_ack", {61'd0, count}, 64'd0);
    chk("t6_req_ack",   {63'd0, mem_req}, 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
